// File: rtl/mat_mul_seq.sv
// Sequential signed NxN matrix multiplier (C = A*B, optionally + previous C) using one MAC per cycle.
// Results saturate or wrap to OW bits; ovf flags any element that did not fit.
module mat_mul_seq #(
  parameter int unsigned N   = 3,
  parameter int unsigned DW  = 4,
  parameter int unsigned OW  = 16,
  parameter int unsigned SAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              acc_en,
  input  logic [N*N*DW-1:0] a,
  input  logic [N*N*DW-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*N*OW-1:0] out,
  output logic              ovf
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = 2 * DW + $clog2(N) + 1;
  localparam int unsigned RW = ((SW > OW) ? SW : OW) + 1;
  localparam logic signed [RW-1:0] MaxV = RW'({1'b0, {(OW - 1){1'b1}}});
  localparam logic signed [RW-1:0] MinV = ~MaxV;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e              state_q;
  logic [N*N*DW-1:0]   a_q, b_q;
  logic                acc_q;
  logic [CW-1:0]       i_q, j_q, k_q;
  logic signed [SW-1:0] sum_q, sum_nx;

  int unsigned          ia, ib, ic;
  logic signed [DW-1:0] ea, eb;
  logic signed [2*DW-1:0] prod;
  logic signed [OW-1:0] old_el, res_el;
  logic signed [RW-1:0] res;
  logic                 res_ovf;

  always_comb begin
    ia     = 32'(i_q) * N + 32'(k_q);
    ib     = 32'(k_q) * N + 32'(j_q);
    ic     = 32'(i_q) * N + 32'(j_q);
    ea     = a_q[ia*DW +: DW];
    eb     = b_q[ib*DW +: DW];
    prod   = ea * eb;
    sum_nx = sum_q + SW'(prod);
    // Old element is read here, before the same-cycle overwrite.
    old_el = out[ic*OW +: OW];
    res    = RW'(sum_nx) + (acc_q ? RW'(old_el) : '0);
    res_ovf = (res > MaxV) || (res < MinV);
    if (SAT != 0 && res > MaxV) begin
      res_el = MaxV[OW-1:0];
    end else if (SAT != 0 && res < MinV) begin
      res_el = MinV[OW-1:0];
    end else begin
      res_el = res[OW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= 1'b0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      sum_q     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            acc_q    <= acc_en;
            ovf      <= 1'b0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            sum_q    <= '0;
            in_ready <= 1'b0;
            state_q  <= StCalc;
          end
        end
        StCalc: begin
          if (k_q == CW'(N - 1)) begin
            out[ic*OW +: OW] <= res_el;
            if (res_ovf) ovf <= 1'b1;
            sum_q <= '0;
            k_q   <= '0;
            if (j_q == CW'(N - 1)) begin
              j_q <= '0;
              if (i_q == CW'(N - 1)) begin
                i_q       <= '0;
                out_valid <= 1'b1;
                state_q   <= StDone;
              end else begin
                i_q <= i_q + 1'b1;
              end
            end else begin
              j_q <= j_q + 1'b1;
            end
          end else begin
            sum_q <= sum_nx;
            k_q   <= k_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
